// File: rtl/pipe_sequencer.sv
// Stall/flush sequencer for the four-stage pipe: turns branch, hazard, memory
// handshake and halt requests into one coherent set of stage enables and bubbles.
module pipe_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       br_taken,
  input  logic       hazard,
  input  logic       mem_req,
  input  logic       mem_ack,
  input  logic       halt_req,
  output logic [3:0] en,
  output logic [3:0] bubble,
  output logic       pc_load,
  output logic [1:0] state,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_WAIT_MAX - 1);

  state_t     cur_state, nxt_state;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       br_pend, br_pend_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      br_pend   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      br_pend   <= br_pend_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    nxt_state     = cur_state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    br_pend_nxt   = br_pend;
    en            = 4'b0000;
    bubble        = 4'b0000;
    pc_load       = 1'b0;
    timeout_err   = 1'b0;

    unique case (cur_state)
      RUN: begin
        if (halt_req) begin
          nxt_state = HALT;
        end else if (mem_req && !mem_ack) begin
          br_pend_nxt  = br_taken;
          wait_cnt_nxt = '0;
          nxt_state    = MEMWAIT;
        end else if (br_taken) begin
          // The hazarding instruction is killed by the flush, so hazard is moot.
          pc_load       = 1'b1;
          en            = 4'b1111;
          bubble        = 4'b0111;
          flush_cnt_nxt = FLUSH_INIT;
          nxt_state     = FLUSH;
        end else if (hazard) begin
          en     = 4'b1100;
          bubble = 4'b0100;
        end else begin
          en = 4'b1111;
        end
      end

      FLUSH: begin
        en     = 4'b1111;
        bubble = 4'b0001;
        if (halt_req) begin
          nxt_state = HALT;
        end else if (flush_cnt == 4'd0) begin
          nxt_state = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end

      MEMWAIT: begin
        if (wait_cnt != 8'hFF) wait_cnt_nxt = wait_cnt + 8'd1;
        // Ack is checked before the timeout so a last-moment ack still completes.
        if (mem_ack) begin
          br_pend_nxt = 1'b0;
          en          = 4'b1111;
          if (br_pend) begin
            pc_load       = 1'b1;
            bubble        = 4'b0111;
            flush_cnt_nxt = FLUSH_INIT;
            nxt_state     = FLUSH;
          end else begin
            nxt_state = RUN;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_err = 1'b1;
          nxt_state   = HALT;
        end
      end

      HALT: ;

      default: nxt_state = RUN;
    endcase

    if (rst) begin
      en          = 4'b0000;
      bubble      = 4'b1111;
      pc_load     = 1'b0;
      timeout_err = 1'b0;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer (FLUSH_CYCLES=2, MEM_WAIT_MAX=4); each step
// drives inputs after the falling edge and checks the combinational outputs.
module tb_pipe_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br_taken = 1'b0, hazard = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, halt_req = 1'b0;
  logic [3:0] en, bubble;
  logic       pc_load, timeout_err;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  pipe_sequencer #(.FLUSH_CYCLES(2), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .hazard(hazard),
    .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req),
    .en(en), .bubble(bubble), .pc_load(pc_load), .state(state),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs: r=rst b=br_taken h=hazard q=mem_req a=mem_ack t=halt_req.
  // Expected: state, en, bubble, pc_load, timeout_err.
  task automatic cyc(input string tag,
                     input logic r, input logic b, input logic h,
                     input logic q, input logic a, input logic t,
                     input logic [1:0] x_st, input logic [3:0] x_en,
                     input logic [3:0] x_bub, input logic x_pcl, input logic x_to);
    logic [11:0] obs, exp_v;
    @(negedge clk);
    rst = r; br_taken = b; hazard = h; mem_req = q; mem_ack = a; halt_req = t;
    #1;
    obs   = {state, en, bubble, pc_load, timeout_err};
    exp_v = {x_st, x_en, x_bub, x_pcl, x_to};
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed st/en/bub/pcl/to=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    //          tag           r  b  h  q  a  t   st    en       bub      pcl to
    // Reset, then hazard stall for two cycles.
    cyc("rst0",         1, 0, 0, 0, 0, 0, 2'd0, 4'b0000, 4'b1111, 0, 0);
    cyc("rst1",         1, 0, 1, 0, 0, 0, 2'd0, 4'b0000, 4'b1111, 0, 0);
    cyc("haz0",         0, 0, 1, 0, 0, 0, 2'd0, 4'b1100, 4'b0100, 0, 0);
    cyc("haz1",         0, 0, 1, 0, 0, 0, 2'd0, 4'b1100, 4'b0100, 0, 0);
    cyc("run0",         0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Taken branch (with hazard ignored), two flush cycles ignoring br/hazard.
    cyc("br_resolve",   0, 1, 1, 0, 0, 0, 2'd0, 4'b1111, 4'b0111, 1, 0);
    cyc("flush0",       0, 1, 1, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("flush1",       0, 0, 0, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("br_done",      0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Same-cycle ack costs nothing.
    cyc("mem_fast",     0, 0, 0, 1, 1, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);
    cyc("mem_fast_nx",  0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Memory wait, ack three cycles after the request; halt ignored while waiting.
    cyc("mw_req",       0, 0, 0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("mw_w0",        0, 0, 0, 1, 0, 1, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("mw_w1",        0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("mw_ack",       0, 0, 0, 1, 1, 0, 2'd2, 4'b1111, 4'b0000, 0, 0);
    cyc("mw_done",      0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Branch and memory in the same cycle: pc_load deferred to the ack cycle.
    cyc("bm_req",       0, 1, 0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("bm_w0",        0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("bm_ack",       0, 0, 0, 1, 1, 0, 2'd2, 4'b1111, 4'b0111, 1, 0);
    cyc("bm_flush0",    0, 0, 0, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("bm_flush1",    0, 0, 0, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("bm_done",      0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Timeout: pulse in the 4th MEMWAIT cycle, then sticky HALT.
    cyc("to_req",       0, 0, 0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("to_w0",        0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("to_w1",        0, 0, 0, 1, 0, 1, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("to_w2",        0, 1, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("to_pulse",     0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 1);
    cyc("halt0",        0, 1, 0, 0, 0, 1, 2'd3, 4'b0000, 4'b0000, 0, 0);
    cyc("halt1",        0, 0, 1, 1, 1, 0, 2'd3, 4'b0000, 4'b0000, 0, 0);
    cyc("halt_rst",     1, 0, 0, 0, 0, 0, 2'd3, 4'b0000, 4'b1111, 0, 0);
    cyc("halt_out",     0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Reset mid-FLUSH: back to RUN, then a fresh branch flushes for full length.
    cyc("rf_br",        0, 1, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0111, 1, 0);
    cyc("rf_rst",       1, 0, 0, 0, 0, 0, 2'd1, 4'b0000, 4'b1111, 0, 0);
    cyc("rf_run",       0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);
    cyc("rf_br2",       0, 1, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0111, 1, 0);
    cyc("rf_flush0",    0, 0, 0, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("rf_flush1",    0, 0, 0, 0, 0, 0, 2'd1, 4'b1111, 4'b0001, 0, 0);
    cyc("rf_done",      0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Reset mid-MEMWAIT with a pending branch and a same-cycle ack: no pc_load,
    // pending branch dropped, and an ack in the last wait cycle beats the timeout.
    cyc("rm_req",       0, 1, 0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_w0",        0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_rst",       1, 0, 0, 1, 1, 0, 2'd2, 4'b0000, 4'b1111, 0, 0);
    cyc("rm_req2",      0, 0, 0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_w0b",       0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_w1b",       0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_w2b",       0, 0, 0, 1, 0, 0, 2'd2, 4'b0000, 4'b0000, 0, 0);
    cyc("rm_ack_last",  0, 0, 0, 1, 1, 0, 2'd2, 4'b1111, 4'b0000, 0, 0);
    cyc("rm_done",      0, 0, 0, 0, 0, 0, 2'd0, 4'b1111, 4'b0000, 0, 0);

    // Halt from RUN beats memory and branch requests.
    cyc("run_halt",     0, 1, 0, 1, 0, 1, 2'd0, 4'b0000, 4'b0000, 0, 0);
    cyc("run_halted",   0, 0, 0, 0, 0, 0, 2'd3, 4'b0000, 4'b0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Central stall/flush sequencer for the four-stage pipelined processor. It takes branch resolution from the stage-4 control-code stage, RAW hazard detection from decode, and the data-memory handshake. From these it drives per-stage buffer enables, NOP-bubble injection and PC reload, so that no two stages ever disagree about whether the pipe is moving.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles fetch is held bubbled after a taken branch (1–15)
- MEM_WAIT_MAX, 15: max cycles waiting for mem_ack before fault (1–255)

Ports:
- clk  in  1  global clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- br_taken  in  1  stage 4 resolved a taken jump/call/return this cycle
- hazard  in  1  stage 2 operand depends on a stage 3/4 result not yet written back
- mem_req  in  1  stage 4 instruction needs data memory this cycle (WR, LDA, PSH, POP, CUD/CCD)
- mem_ack  in  1  memory completes the request this cycle
- halt_req  in  1  stop the pipe (HLT / debug)
- en  out  4  buffer enable per stage, bit0 = fetch … bit3 = stage 4
- bubble  out  4  force opcode 8'h00 (NOP) into stage n buffer on this edge
- pc_load  out  1  load PC from branch target this cycle
- state  out  2  0 RUN, 1 FLUSH, 2 MEMWAIT, 3 HALT
- timeout_err  out  1  one-cycle pulse on memory timeout

## Operation
- Outputs are combinational from state, counters and inputs. State, counters and pending flag are registered.
- **Reset.**
  - While rst=1: en=0000, bubble=1111, pc_load=0, timeout_err=0.
  - On the clk edge with rst=1: state←RUN, counters←0, br_pend←0.
  - Reset takes effect from any state.
- **RUN.** Evaluated in priority order:
  1. halt_req: en=0000, bubble=0000; next HALT.
  2. mem_req & ~mem_ack: en=0000, bubble=0000; br_pend←br_taken; wait counter←0; next MEMWAIT.
  3. br_taken (memory done or not needed): pc_load=1, en=1111, bubble=0111; flush counter←FLUSH_CYCLES-1; next FLUSH. hazard is ignored because the dependent instruction is killed.
  4. hazard: en=1100, bubble=0100. Fetch and decode hold, a NOP is inserted into stage 3, stays RUN.
  5. Otherwise: en=1111, bubble=0000.
- **FLUSH.**
  - Outputs: en=1111, bubble=0001. br_taken and hazard are ignored because only NOPs are downstream.
  - Counter decrements. At 0, next RUN.
  - halt_req has priority and goes to HALT.
- **MEMWAIT.**
  - Outputs: en=0000, bubble=0000; wait counter increments.
  - mem_ack: if br_pend, same-cycle pc_load=1, en=1111, bubble=0111, go FLUSH. Else en=1111, go RUN. Clear br_pend.
  - No ack and counter = MEM_WAIT_MAX-1: timeout_err=1 this cycle, next HALT.
  - mem_ack and timeout in the same cycle: ack wins.
  - halt_req is ignored until the access completes or times out.
- **HALT.**
  - Outputs: en=0000, bubble=0000, pc_load=0.
  - Sticky; left only by rst.

## Timing
- Hazard stall: zero added latency, one bubble per cycle hazard is high.
- Taken branch: pc_load in the resolve cycle. Fetch bubbled for FLUSH_CYCLES cycles after it, so the first target instruction enters stage 1 on cycle FLUSH_CYCLES+1.
- Memory ack on the request cycle costs no stall. Otherwise the stall is the number of cycles until ack.
- Timeout: timeout_err pulses in the MEM_WAIT_MAX-th cycle of MEMWAIT, and HALT is entered on the next edge.
- Counters are sized to their parameter's maximum with no wrap. The wait counter saturates if MEMWAIT is somehow held.

## Test plan
- **Reset and stalls.** rst high 2 cycles, then hazard=1 for 2 cycles → en=0000/bubble=1111 during reset, then en=1100, bubble=0100 for exactly 2 cycles, state stays 0.
- **Branch flush.** br_taken pulse with FLUSH_CYCLES=2 → pc_load=1 and bubble=0111 in the pulse cycle, then 2 cycles of state=1 with bubble=0001, then state=0 with en=1111.
- **Memory wait.** mem_req with mem_ack after 3 cycles → en=0000 for 3 cycles, state=2, en=1111 in the ack cycle, RUN next.
- **Branch plus memory.** br_taken+mem_req same cycle, ack 2 cycles later → no pc_load until the ack cycle, then pc_load=1, bubble=0111, FLUSH.
- **Timeout.** MEM_WAIT_MAX=4, mem_req, no ack → timeout_err high in the 4th MEMWAIT cycle, state=3 after. halt_req/br_taken ignored; rst returns to RUN.
- **Reset mid-operation.** rst asserted mid-FLUSH and mid-MEMWAIT → RUN with counters cleared on the next edge, no pc_load emitted.
